// File: rtl/baud_tick_gen.sv
// Programmable UART baud tick generator: fractional sample-period divider with
// oversampling phase counter, derived bit/mid-bit ticks and boundary-safe reload.
module baud_tick_gen #(
    parameter int DIV_WIDTH    = 16,
    parameter int FRAC_WIDTH   = 4,
    parameter int OVERSAMPLE   = 16,
    parameter int DEFAULT_DIV  = 196,
    parameter int DEFAULT_FRAC = 0
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          enable,
    input  logic [DIV_WIDTH-1:0]          div_int,
    input  logic [FRAC_WIDTH-1:0]         div_frac,
    input  logic                          div_load,
    input  logic                          restart,
    output logic                          div_pending,
    output logic                          sample_tick,
    output logic                          bit_tick,
    output logic                          mid_tick,
    output logic [$clog2(OVERSAMPLE)-1:0] phase
);
    localparam int PW = $clog2(OVERSAMPLE);
    localparam logic [PW-1:0] PHASE_LAST    = PW'(OVERSAMPLE - 1);
    localparam logic [PW-1:0] PHASE_PRE_MID = PW'(OVERSAMPLE / 2 - 1);

    logic [DIV_WIDTH-1:0]  act_int_reg, shd_int_reg, cnt_reg;
    logic [FRAC_WIDTH-1:0] act_frac_reg, shd_frac_reg, frac_acc_reg;
    logic                  pending_reg, long_reg;
    logic [PW-1:0]         phase_reg;
    logic                  sample_tick_reg, bit_tick_reg, mid_tick_reg;

    logic [DIV_WIDTH-1:0]  eff_int;
    logic [DIV_WIDTH:0]    last_cnt;
    logic [FRAC_WIDTH:0]   frac_sum;
    logic                  terminal;
    logic                  apply;

    // Divisors below 2 would leave the tick permanently high, so clamp them.
    assign eff_int  = (act_int_reg < DIV_WIDTH'(2)) ? DIV_WIDTH'(2) : act_int_reg;
    assign last_cnt = {1'b0, eff_int} - (DIV_WIDTH + 1)'(1) + {{DIV_WIDTH{1'b0}}, long_reg};
    assign frac_sum = {1'b0, frac_acc_reg} + {1'b0, act_frac_reg};
    // >= rather than == so a divisor that shrinks while frozen cannot strand cnt past the end.
    assign terminal = enable && ({1'b0, cnt_reg} >= last_cnt);
    assign apply    = pending_reg && (terminal || !enable || restart);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            act_int_reg     <= DIV_WIDTH'(DEFAULT_DIV);
            act_frac_reg    <= FRAC_WIDTH'(DEFAULT_FRAC);
            shd_int_reg     <= DIV_WIDTH'(DEFAULT_DIV);
            shd_frac_reg    <= FRAC_WIDTH'(DEFAULT_FRAC);
            pending_reg     <= 1'b0;
            cnt_reg         <= '0;
            frac_acc_reg    <= '0;
            long_reg        <= 1'b0;
            phase_reg       <= '0;
            sample_tick_reg <= 1'b0;
            bit_tick_reg    <= 1'b0;
            mid_tick_reg    <= 1'b0;
        end else begin
            if (div_load) begin
                shd_int_reg  <= div_int;
                shd_frac_reg <= div_frac;
            end
            // A load coinciding with an apply wins: it is queued for the next boundary.
            if (div_load)
                pending_reg <= 1'b1;
            else if (apply)
                pending_reg <= 1'b0;
            if (apply) begin
                act_int_reg  <= shd_int_reg;
                act_frac_reg <= shd_frac_reg;
            end

            if (restart) begin
                cnt_reg         <= '0;
                frac_acc_reg    <= '0;
                long_reg        <= 1'b0;
                phase_reg       <= '0;
                sample_tick_reg <= 1'b0;
                bit_tick_reg    <= 1'b0;
                mid_tick_reg    <= 1'b0;
            end else if (terminal) begin
                cnt_reg         <= '0;
                frac_acc_reg    <= apply ? '0 : frac_sum[FRAC_WIDTH-1:0];
                long_reg        <= apply ? 1'b0 : frac_sum[FRAC_WIDTH];
                phase_reg       <= phase_reg + PW'(1);
                sample_tick_reg <= 1'b1;
                bit_tick_reg    <= (phase_reg == PHASE_LAST);
                mid_tick_reg    <= (phase_reg == PHASE_PRE_MID);
            end else begin
                if (enable)
                    cnt_reg <= cnt_reg + DIV_WIDTH'(1);
                if (apply) begin
                    frac_acc_reg <= '0;
                    long_reg     <= 1'b0;
                end
                sample_tick_reg <= 1'b0;
                bit_tick_reg    <= 1'b0;
                mid_tick_reg    <= 1'b0;
            end
        end
    end

    assign div_pending = pending_reg;
    assign sample_tick = sample_tick_reg;
    assign bit_tick    = bit_tick_reg;
    assign mid_tick    = mid_tick_reg;
    assign phase       = phase_reg;

endmodule

// File: tb/tb_baud_tick_gen.sv
// Directed self-checking bench for baud_tick_gen: period timing, fractional
// divide, reload, clamping, restart, enable freeze and async reset.
module tb_baud_tick_gen;
    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic [15:0] div_int;
    logic [3:0]  div_frac;
    logic        div_load;
    logic        restart;
    logic        div_pending;
    logic        sample_tick;
    logic        bit_tick;
    logic        mid_tick;
    logic [3:0]  phase;

    int checks = 0;
    int errors = 0;

    baud_tick_gen #(
        .DIV_WIDTH(16), .FRAC_WIDTH(4), .OVERSAMPLE(16),
        .DEFAULT_DIV(196), .DEFAULT_FRAC(0)
    ) dut (
        .clk(clk), .reset(reset), .enable(enable),
        .div_int(div_int), .div_frac(div_frac), .div_load(div_load),
        .restart(restart), .div_pending(div_pending),
        .sample_tick(sample_tick), .bit_tick(bit_tick), .mid_tick(mid_tick),
        .phase(phase)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Returns the number of edges until the selected tick is seen, or -1 on timeout.
    task automatic wait_for(input int which, input int limit, output int n);
        n = -1;
        for (int i = 1; i <= limit; i++) begin
            step();
            if ((which == 0 && sample_tick) || (which == 1 && bit_tick) ||
                (which == 2 && mid_tick)) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic load_div(input int di, input int df);
        div_int  = 16'(di);
        div_frac = 4'(df);
        div_load = 1'b1;
        step();
        div_load = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) step();
        checks++; if (sample_tick !== 1'b0) begin errors++; $display("FAIL reset_sample: got %0b, expected 0", sample_tick); end
        checks++; if ({bit_tick, mid_tick} !== 2'b00) begin errors++; $display("FAIL reset_bit_mid: got %b, expected 00", {bit_tick, mid_tick}); end
        checks++; if (phase !== 4'd0) begin errors++; $display("FAIL reset_phase: got %0d, expected 0", phase); end
        checks++; if (div_pending !== 1'b0) begin errors++; $display("FAIL reset_pending: got %0b, expected 0", div_pending); end
        reset = 1'b0;
        $display("test_reset done");
    endtask

    task automatic test_default_period();
        int n;
        wait_for(0, 400, n);
        checks++; if (n !== 196) begin errors++; $display("FAIL first_tick: got %0d, expected 196", n); end
        checks++; if (phase !== 4'd1) begin errors++; $display("FAIL first_phase: got %0d, expected 1", phase); end
        step();
        checks++; if (sample_tick !== 1'b0) begin errors++; $display("FAIL tick_width: got %0b, expected 0", sample_tick); end
        wait_for(2, 4000, n);
        checks++; if (n !== 1371) begin errors++; $display("FAIL first_mid: got %0d, expected 1371", n); end
        checks++; if ({sample_tick, bit_tick, phase} !== {1'b1, 1'b0, 4'd8}) begin errors++; $display("FAIL mid_state: got st=%0b bt=%0b ph=%0d, expected st=1 bt=0 ph=8", sample_tick, bit_tick, phase); end
        wait_for(1, 4000, n);
        checks++; if (n !== 1568) begin errors++; $display("FAIL first_bit: got %0d, expected 1568", n); end
        checks++; if ({sample_tick, mid_tick, phase} !== {1'b1, 1'b0, 4'd0}) begin errors++; $display("FAIL bit_state: got st=%0b mt=%0b ph=%0d, expected st=1 mt=0 ph=0", sample_tick, mid_tick, phase); end
        wait_for(2, 4000, n);
        checks++; if (n !== 1568) begin errors++; $display("FAIL bit_to_mid: got %0d, expected 1568", n); end
        $display("test_default_period done");
    endtask

    task automatic test_fractional();
        int n, n1, n2, total;
        load_div(10, 8);
        checks++; if (div_pending !== 1'b1) begin errors++; $display("FAIL frac_pending_set: got %0b, expected 1", div_pending); end
        wait_for(0, 400, n);
        checks++; if (n !== 195) begin errors++; $display("FAIL frac_old_period: got %0d, expected 195", n); end
        checks++; if (div_pending !== 1'b0) begin errors++; $display("FAIL frac_pending_clr: got %0b, expected 0", div_pending); end
        wait_for(0, 40, n);
        checks++; if (n !== 10) begin errors++; $display("FAIL frac_first_period: got %0d, expected 10", n); end
        total = 0;
        n1 = 0;
        n2 = 0;
        for (int k = 0; k < 32; k++) begin
            wait_for(0, 40, n);
            if (k == 0) n1 = n;
            if (k == 1) n2 = n;
            total += n;
        end
        checks++; if ({n1, n2} !== {32'd10, 32'd11}) begin errors++; $display("FAIL frac_alternate: got %0d/%0d, expected 10/11", n1, n2); end
        checks++; if (total !== 336) begin errors++; $display("FAIL frac_span32: got %0d, expected 336", total); end
        $display("test_fractional done");
    endtask

    task automatic test_midperiod_load();
        int n;
        load_div(196, 0);
        wait_for(0, 40, n);
        checks++; if (div_pending !== 1'b0) begin errors++; $display("FAIL reload196_pending: got %0b, expected 0", div_pending); end
        repeat (50) step();
        load_div(99, 0);
        checks++; if (div_pending !== 1'b1) begin errors++; $display("FAIL mid_load_pending: got %0b, expected 1", div_pending); end
        load_div(20, 0);
        wait_for(0, 400, n);
        checks++; if (n !== 144) begin errors++; $display("FAIL mid_load_old_len: got %0d, expected 144", n); end
        checks++; if (div_pending !== 1'b0) begin errors++; $display("FAIL mid_load_applied: got %0b, expected 0", div_pending); end
        wait_for(0, 400, n);
        checks++; if (n !== 20) begin errors++; $display("FAIL last_load_wins: got %0d, expected 20", n); end
        $display("test_midperiod_load done");
    endtask

    task automatic test_clamp();
        int n, ticks, doubles;
        logic prev;
        load_div(0, 0);
        wait_for(0, 40, n);
        checks++; if (n !== 19) begin errors++; $display("FAIL clamp0_apply: got %0d, expected 19", n); end
        ticks = 0;
        doubles = 0;
        prev = 1'b1;
        for (int k = 0; k < 10; k++) begin
            step();
            if (sample_tick) ticks++;
            if (sample_tick && prev) doubles++;
            prev = sample_tick;
        end
        checks++; if (ticks !== 5) begin errors++; $display("FAIL clamp0_ticks: got %0d, expected 5", ticks); end
        checks++; if (doubles !== 0) begin errors++; $display("FAIL clamp0_back_to_back: got %0d, expected 0", doubles); end
        load_div(1, 0);
        wait_for(0, 10, n);
        checks++; if (n !== 1) begin errors++; $display("FAIL clamp1_apply: got %0d, expected 1", n); end
        wait_for(0, 10, n);
        checks++; if (n !== 2) begin errors++; $display("FAIL clamp1_period_a: got %0d, expected 2", n); end
        step();
        checks++; if (sample_tick !== 1'b0) begin errors++; $display("FAIL clamp1_width: got %0b, expected 0", sample_tick); end
        wait_for(0, 10, n);
        checks++; if (n !== 1) begin errors++; $display("FAIL clamp1_period_b: got %0d, expected 1", n); end
        $display("test_clamp done");
    endtask

    task automatic test_restart();
        int n;
        load_div(10, 0);
        wait_for(0, 10, n);
        restart = 1'b1;
        step();
        restart = 1'b0;
        checks++; if ({sample_tick, phase} !== {1'b0, 4'd0}) begin errors++; $display("FAIL restart_state: got st=%0b ph=%0d, expected st=0 ph=0", sample_tick, phase); end
        wait_for(0, 40, n);
        checks++; if (n !== 10) begin errors++; $display("FAIL restart_first: got %0d, expected 10", n); end
        repeat (6) wait_for(0, 40, n);
        checks++; if (phase !== 4'd7) begin errors++; $display("FAIL restart_phase7: got %0d, expected 7", phase); end
        repeat (9) step();
        restart = 1'b1;
        step();
        restart = 1'b0;
        checks++; if ({sample_tick, mid_tick, phase} !== {1'b0, 1'b0, 4'd0}) begin errors++; $display("FAIL restart_on_terminal: got st=%0b mt=%0b ph=%0d, expected st=0 mt=0 ph=0", sample_tick, mid_tick, phase); end
        wait_for(0, 40, n);
        checks++; if (n !== 10) begin errors++; $display("FAIL restart_next_tick: got %0d, expected 10", n); end
        wait_for(1, 400, n);
        checks++; if (n !== 150) begin errors++; $display("FAIL restart_bit_tick: got %0d, expected 150", n); end
        $display("test_restart done");
    endtask

    task automatic test_enable_and_async_reset();
        int n, ticks;
        load_div(50, 0);
        wait_for(0, 20, n);
        checks++; if (n !== 9) begin errors++; $display("FAIL en_apply50: got %0d, expected 9", n); end
        repeat (30) step();
        enable = 1'b0;
        ticks = 0;
        for (int k = 0; k < 100; k++) begin
            step();
            if (sample_tick || bit_tick || mid_tick) ticks++;
        end
        checks++; if (ticks !== 0) begin errors++; $display("FAIL disabled_ticks: got %0d, expected 0", ticks); end
        checks++; if (phase !== 4'd1) begin errors++; $display("FAIL disabled_phase: got %0d, expected 1", phase); end
        enable = 1'b1;
        wait_for(0, 100, n);
        checks++; if (n !== 20) begin errors++; $display("FAIL resume_cnt30: got %0d, expected 20", n); end
        checks++; if (phase !== 4'd2) begin errors++; $display("FAIL resume_phase: got %0d, expected 2", phase); end
        load_div(7, 0);
        repeat (5) step();
        #2;
        reset = 1'b1;
        #1;
        checks++; if ({sample_tick, bit_tick, mid_tick, div_pending} !== 4'b0000) begin errors++; $display("FAIL async_reset_outputs: got %b, expected 0000", {sample_tick, bit_tick, mid_tick, div_pending}); end
        checks++; if (phase !== 4'd0) begin errors++; $display("FAIL async_reset_phase: got %0d, expected 0", phase); end
        reset = 1'b0;
        wait_for(0, 400, n);
        checks++; if (n !== 196) begin errors++; $display("FAIL post_reset_default: got %0d, expected 196", n); end
        $display("test_enable_and_async_reset done");
    endtask

    initial begin
        reset    = 1'b1;
        enable   = 1'b1;
        div_int  = '0;
        div_frac = '0;
        div_load = 1'b0;
        restart  = 1'b0;
        test_reset();
        test_default_period();
        test_fractional();
        test_midperiod_load();
        test_clamp();
        test_restart();
        test_enable_and_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
